data_sram_responder: RTL and testbench



---
 rtl/data_sram_responder.sv | 166 ++++++++++++++++
 tb/tb_data_sram_responder.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_sram_responder.sv
// Data-side SRAM-like responder: word RAM plus a small MMIO block (LED, switch,
// timer with compare interrupt). One-cycle read latency, no backpressure.
module data_sram_responder #(
    parameter int          ADDR_W    = 12,
    parameter logic [31:0] MMIO_BASE = 32'hBFAF_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic [15:0] led,
    input  logic [7:0]  switch,
    output logic        timer_irq
);

    localparam int DEPTH = 1 << ADDR_W;

    localparam logic [13:0] OFF_LED    = 14'd0;
    localparam logic [13:0] OFF_SWITCH = 14'd1;
    localparam logic [13:0] OFF_TIMER  = 14'd2;
    localparam logic [13:0] OFF_CMP    = 14'd3;
    localparam logic [13:0] OFF_STATUS = 14'd4;

    // Which register currently drives rdata; the RAM output register has no
    // reset, so reset points the mux at a constant zero instead.
    typedef enum logic [1:0] {
        SRC_ZERO = 2'd0,
        SRC_RAM  = 2'd1,
        SRC_MMIO = 2'd2
    } rd_src_e;

    function automatic logic [31:0] byte_merge(
        input logic [31:0] old_v,
        input logic [31:0] new_v,
        input logic [3:0]  be
    );
        logic [31:0] mask;
        mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        return (old_v & ~mask) | (new_v & mask);
    endfunction

    logic [31:0] mem [DEPTH];

    logic              is_mmio;
    logic [13:0]       mmio_off;
    logic [ADDR_W-1:0] ram_idx;
    logic              rd_req;
    logic              wr_req;
    logic              unused_addr_bits;

    rd_src_e     src_q, src_d;
    logic [31:0] ram_rdata_q;
    logic [31:0] mmio_rdata_q, mmio_rdata_d;
    logic [31:0] mmio_rd_val;
    logic [15:0] led_q, led_d;
    logic [31:0] timer_q, timer_d;
    logic [31:0] cmp_q, cmp_d;
    logic        pend_q, pend_d;
    logic        w1c_clr;
    logic [7:0]  sw_meta_q;
    logic [7:0]  sw_sync_q;

    assign is_mmio          = (data_sram_addr[31:16] == MMIO_BASE[31:16]);
    assign mmio_off         = data_sram_addr[15:2];
    assign ram_idx          = data_sram_addr[ADDR_W+1:2];
    assign rd_req           = data_sram_en && (data_sram_wen == 4'b0000);
    assign wr_req           = data_sram_en && (data_sram_wen != 4'b0000);
    assign unused_addr_bits = ^data_sram_addr[1:0];

    // Plain single-port RAM; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (wr_req && !is_mmio) begin
            for (int b = 0; b < 4; b++) begin
                if (data_sram_wen[b]) begin
                    mem[ram_idx][8*b +: 8] <= data_sram_wdata[8*b +: 8];
                end
            end
        end
        if (rd_req && !is_mmio) begin
            ram_rdata_q <= mem[ram_idx];
        end
    end

    always_comb begin
        mmio_rd_val = 32'h0;
        case (mmio_off)
            OFF_LED:    mmio_rd_val = {16'h0, led_q};
            OFF_SWITCH: mmio_rd_val = {24'h0, sw_sync_q};
            OFF_TIMER:  mmio_rd_val = timer_q;
            OFF_CMP:    mmio_rd_val = cmp_q;
            OFF_STATUS: mmio_rd_val = {31'h0, pend_q};
            default:    mmio_rd_val = 32'h0;
        endcase
    end

    always_comb begin
        src_d        = src_q;
        mmio_rdata_d = mmio_rdata_q;
        led_d        = led_q;
        timer_d      = timer_q + 32'd1;
        cmp_d        = cmp_q;
        w1c_clr      = 1'b0;

        if (rd_req) begin
            if (is_mmio) begin
                src_d        = SRC_MMIO;
                mmio_rdata_d = mmio_rd_val;
            end else begin
                src_d = SRC_RAM;
            end
        end

        if (wr_req && is_mmio) begin
            case (mmio_off)
                OFF_LED: begin
                    if (data_sram_wen[0]) led_d[7:0]  = data_sram_wdata[7:0];
                    if (data_sram_wen[1]) led_d[15:8] = data_sram_wdata[15:8];
                end
                OFF_TIMER:  timer_d = byte_merge(timer_q, data_sram_wdata, data_sram_wen);
                OFF_CMP:    cmp_d   = byte_merge(cmp_q, data_sram_wdata, data_sram_wen);
                OFF_STATUS: w1c_clr = data_sram_wen[0] && data_sram_wdata[0];
                default:    ;
            endcase
        end

        // A compare match wins over a same-cycle W1C.
        pend_d = (timer_q == cmp_q) || (pend_q && !w1c_clr);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            src_q        <= SRC_ZERO;
            mmio_rdata_q <= 32'h0;
            led_q        <= 16'h0;
            timer_q      <= 32'h0;
            cmp_q        <= 32'hFFFF_FFFF;
            pend_q       <= 1'b0;
            sw_meta_q    <= 8'h0;
            sw_sync_q    <= 8'h0;
        end else begin
            src_q        <= src_d;
            mmio_rdata_q <= mmio_rdata_d;
            led_q        <= led_d;
            timer_q      <= timer_d;
            cmp_q        <= cmp_d;
            pend_q       <= pend_d;
            sw_meta_q    <= switch;
            sw_sync_q    <= sw_meta_q;
        end
    end

    always_comb begin
        case (src_q)
            SRC_RAM:  data_sram_rdata = ram_rdata_q;
            SRC_MMIO: data_sram_rdata = mmio_rdata_q;
            default:  data_sram_rdata = 32'h0;
        endcase
    end

    assign led       = led_q;
    assign timer_irq = pend_q;

endmodule

// File: tb/tb_data_sram_responder.sv
// Bench for data_sram_responder: directed steps followed by random traffic,
// every cycle compared against a transaction-level model of the address map.
module tb_data_sram_responder;

    localparam logic [31:0] BASE = 32'hBFAF_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        data_sram_en;
    logic [3:0]  data_sram_wen;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;
    logic [15:0] led;
    logic [7:0]  switch;
    logic        timer_irq;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model state
    logic [31:0] m_ram [int];
    logic [31:0] m_rdata;
    bit          m_known;
    logic [15:0] m_led;
    logic [31:0] m_timer;
    logic [31:0] m_cmp;
    bit          m_pend;
    logic [7:0]  m_meta;
    logic [7:0]  m_sync;

    int pool [8];

    data_sram_responder dut (
        .clk             (clk),
        .rst             (rst),
        .data_sram_en    (data_sram_en),
        .data_sram_wen   (data_sram_wen),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata),
        .data_sram_rdata (data_sram_rdata),
        .led             (led),
        .switch          (switch),
        .timer_irq       (timer_irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] wd,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old_v;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    task automatic model_reset();
        m_rdata = 32'h0;
        m_known = 1'b1;
        m_led   = 16'h0;
        m_timer = 32'h0;
        m_cmp   = 32'hFFFF_FFFF;
        m_pend  = 1'b0;
        m_meta  = 8'h0;
        m_sync  = 8'h0;
    endtask

    // Effect of one clock edge on the architectural state of the address map.
    task automatic model_edge(input logic en, input logic [3:0] wen,
                              input logic [31:0] addr, input logic [31:0] wd);
        bit          mmio;
        bit          match;
        bit          clr;
        int          idx;
        logic [15:0] off;
        logic [31:0] nt;
        logic [31:0] tmp;
        mmio  = (addr[31:16] == BASE[31:16]);
        off   = addr[15:0] & 16'hFFFC;
        idx   = int'(addr[13:2]);
        match = (m_timer == m_cmp);
        clr   = 1'b0;
        nt    = m_timer + 1;
        if (en && wen == 4'h0) begin
            m_known = 1'b1;
            if (mmio) begin
                case (off)
                    16'h00:  m_rdata = {16'h0, m_led};
                    16'h04:  m_rdata = {24'h0, m_sync};
                    16'h08:  m_rdata = m_timer;
                    16'h0C:  m_rdata = m_cmp;
                    16'h10:  m_rdata = {31'h0, m_pend};
                    default: m_rdata = 32'h0;
                endcase
            end else if (m_ram.exists(idx)) begin
                m_rdata = m_ram[idx];
            end else begin
                m_known = 1'b0;
            end
        end else if (en) begin
            if (mmio) begin
                case (off)
                    16'h00: begin
                        tmp   = merge({16'h0, m_led}, wd, wen);
                        m_led = tmp[15:0];
                    end
                    16'h08:  nt    = merge(m_timer, wd, wen);
                    16'h0C:  m_cmp = merge(m_cmp, wd, wen);
                    16'h10:  clr   = wen[0] && wd[0];
                    default: ;
                endcase
            end else begin
                tmp = m_ram.exists(idx) ? m_ram[idx] : 32'h0;
                m_ram[idx] = merge(tmp, wd, wen);
            end
        end
        m_timer = nt;
        m_pend  = match || (m_pend && !clr);
        m_sync  = m_meta;
        m_meta  = switch;
    endtask

    task automatic check_model();
        if (m_known) check("rdata_model", data_sram_rdata, m_rdata);
        check("led_model", {16'h0, led}, {16'h0, m_led});
        check("irq_model", {31'h0, timer_irq}, {31'h0, m_pend});
    endtask

    task automatic do_cycle(input logic en, input logic [3:0] wen,
                            input logic [31:0] addr, input logic [31:0] wd);
        data_sram_en    = en;
        data_sram_wen   = wen;
        data_sram_addr  = addr;
        data_sram_wdata = wd;
        @(posedge clk);
        model_edge(en, wen, addr, wd);
        #1;
        check_model();
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] wen);
        do_cycle(1'b1, wen, addr, wd);
    endtask

    task automatic rd(input logic [31:0] addr);
        do_cycle(1'b1, 4'h0, addr, $urandom);
    endtask

    task automatic idle();
        do_cycle(1'b0, 4'($urandom_range(0, 15)), $urandom, $urandom);
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] v;
        int          op;

        rst = 1'b1;
        data_sram_en = 1'b0; data_sram_wen = 4'h0;
        data_sram_addr = 32'h0; data_sram_wdata = 32'h0;
        switch = 8'h0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_rdata", data_sram_rdata, 32'h0);
        check("reset_led", {16'h0, led}, 32'h0);
        check("reset_irq", {31'h0, timer_irq}, 32'h0);
        #3 rst = 1'b0;

        // RAM byte write
        wr(32'h0000_0100, 32'h1122_3344, 4'hF);
        wr(32'h0000_0100, 32'h00AA_0000, 4'b0100);
        rd(32'h0000_0100);
        check("ram_byte", data_sram_rdata, 32'h11AA_3344);

        // Back-to-back RAW, then hold through idles and an unrelated write
        wr(32'h0000_0200, 32'hDEAD_BEEF, 4'hF);
        rd(32'h0000_0200);
        check("raw_b2b", data_sram_rdata, 32'hDEAD_BEEF);
        repeat (3) begin
            idle();
            check("hold_idle", data_sram_rdata, 32'hDEAD_BEEF);
        end
        wr(32'h0000_0204, 32'h1234_5678, 4'hF);
        check("hold_write", data_sram_rdata, 32'hDEAD_BEEF);

        // LED, switch, undefined offset
        wr(BASE, 32'hFFFF_1234, 4'hF);
        check("led_out", {16'h0, led}, 32'h0000_1234);
        rd(BASE);
        check("led_rb", data_sram_rdata, 32'h0000_1234);
        switch = 8'h5A;
        idle();
        idle();
        rd(BASE + 32'h4);
        check("switch_rb", data_sram_rdata, 32'h0000_005A);
        rd(BASE + 32'h20);
        check("undef_rd", data_sram_rdata, 32'h0);

        // Timer readback and wrap
        wr(BASE + 32'h8, 32'hFFFF_FFFE, 4'hF);
        rd(BASE + 32'h8);
        check("timer_n1", data_sram_rdata, 32'hFFFF_FFFE);
        rd(BASE + 32'h8);
        check("timer_n2", data_sram_rdata, 32'hFFFF_FFFF);
        idle();
        rd(BASE + 32'h8);
        check("timer_wrap", data_sram_rdata, 32'h0000_0001);

        // IRQ: CMP=100, TIMER=90, clear stale pending, then count to the match
        wr(BASE + 32'hC, 32'd100, 4'hF);
        wr(BASE + 32'h8, 32'd90, 4'hF);
        wr(BASE + 32'h10, 32'h1, 4'b0001);
        check("irq_cleared", {31'h0, timer_irq}, 32'h0);
        for (int k = 1; k <= 10; k++) begin
            idle();
            if (k == 9)  check("irq_before", {31'h0, timer_irq}, 32'h0);
            if (k == 10) check("irq_rise", {31'h0, timer_irq}, 32'h1);
        end
        wr(BASE + 32'h10, 32'h1, 4'b0001);
        check("irq_w1c", {31'h0, timer_irq}, 32'h0);
        wr(BASE + 32'h8, 32'd99, 4'hF);
        idle();
        wr(BASE + 32'h10, 32'h1, 4'b0001);
        check("irq_set_wins", {31'h0, timer_irq}, 32'h1);

        // Asynchronous reset between request and sample edge
        wr(32'h0000_0300, 32'hCAFE_F00D, 4'hF);
        rd(32'h0000_0100);
        check("pre_reset_rd", data_sram_rdata, 32'h11AA_3344);
        data_sram_en = 1'b1; data_sram_wen = 4'h0; data_sram_addr = 32'h0000_0300;
        #3 rst = 1'b1;
        #1;
        check("async_rdata", data_sram_rdata, 32'h0);
        check("async_led", {16'h0, led}, 32'h0);
        check("async_irq", {31'h0, timer_irq}, 32'h0);
        model_reset();
        @(posedge clk);
        #1;
        check("lost_read", data_sram_rdata, 32'h0);
        #2 rst = 1'b0;
        rd(32'h0000_0300);
        check("ram_kept_a", data_sram_rdata, 32'hCAFE_F00D);
        rd(32'h0000_0100);
        check("ram_kept_b", data_sram_rdata, 32'h11AA_3344);
        rd(BASE + 32'h8);
        check("timer_after_rst", data_sram_rdata, 32'h0000_0002);

        // Random traffic over a small RAM pool (with aliasing) and the MMIO map
        for (int i = 0; i < 8; i++) begin
            pool[i] = $urandom_range(0, (1 << 12) - 1);
            wr(32'(pool[i]) << 2, $urandom, 4'hF);
        end
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 9) == 0) switch = 8'($urandom);
            op = $urandom_range(0, 9);
            v  = $urandom;
            if (op < 4) begin
                a = (32'($urandom_range(0, 16'h7FFF)) << 16)
                  | (32'($urandom_range(0, 3)) << 14)
                  | (32'(pool[$urandom_range(0, 7)]) << 2)
                  | 32'($urandom_range(0, 3));
                if ($urandom_range(0, 1) == 1) rd(a);
                else wr(a, v, 4'($urandom_range(1, 15)));
            end else if (op < 8) begin
                a = BASE | (32'($urandom_range(0, 5)) << 2) | 32'($urandom_range(0, 3));
                if (a[4:2] == 3'd3 && $urandom_range(0, 1) == 1) v = m_timer + 32'($urandom_range(1, 6));
                if ($urandom_range(0, 1) == 1) rd(a);
                else wr(a, v, 4'($urandom_range(1, 15)));
            end else if (op == 8) begin
                rd(BASE | (32'($urandom_range(6, 16'h3FFF)) << 2));
            end else begin
                idle();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
